// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding, default timing constants and a counter-width helper
// for the CPU run controller and its button debouncer.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } run_state_e;

  localparam int unsigned DEF_TICK_DIV = 25_000_000;
  localparam int unsigned DEF_DEB_CYC  = 1_000_000;
  localparam int unsigned DEF_CNT_W    = 16;

  // Bits needed to count 0 .. n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 2) begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Two-flop synchroniser plus stability counter for one mechanical button;
// emits a single-clock press pulse on each accepted 0->1 transition.
module btn_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned      CW       = cnt_width(DEB_CYC);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEB_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any sample that agrees with the accepted level restarts the stability window.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer producing clock-enable and soft-reset strobes for the
// model CPU. Optional breakpoint compare is built when BREAKPOINT_EN is defined.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned DEB_CYC  = DEF_DEB_CYC,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             RESETn,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             rst_btn,
  input  logic             halt_in,
`ifdef BREAKPOINT_EN
  input  logic [7:0]       pc_in,
  input  logic [7:0]       bp_addr,
  input  logic             bp_en,
  output logic             bp_hit,
`endif
  output logic             cpu_ce,
  output logic             cpu_rst,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int unsigned   DW       = cnt_width(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic             run_sync1_q, run_sync2_q, run_prev_q;
  logic [1:0]       sync_vld_q;
  logic             run_rise;
  logic             step_press, rst_press;
  logic             div_last;
  logic             ce;

  run_state_e       state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef BREAKPOINT_EN
  logic             bp_hit_q, bp_hit_d;
  logic             bp_match;
`endif

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_step_deb (
    .clk     (clk),
    .rst_n   (RESETn),
    .btn_i   (step_btn),
    .press_o (step_press)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_rst_deb (
    .clk     (clk),
    .rst_n   (RESETn),
    .btn_i   (rst_btn),
    .press_o (rst_press)
  );

  // Until the synchroniser has filled, the previous sample reads as high so a
  // switch already on at power-up is not mistaken for a fresh rising edge.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      run_sync1_q <= 1'b0;
      run_sync2_q <= 1'b0;
      run_prev_q  <= 1'b0;
      sync_vld_q  <= 2'b00;
    end else begin
      run_sync1_q <= run_sw;
      run_sync2_q <= run_sync1_q;
      sync_vld_q  <= {sync_vld_q[0], 1'b1};
      run_prev_q  <= sync_vld_q[1] ? run_sync2_q : 1'b1;
    end
  end

  assign run_rise = sync_vld_q[1] & run_sync2_q & ~run_prev_q;
  assign div_last = (div_q == DIV_LAST);

`ifdef BREAKPOINT_EN
  assign bp_match = bp_en && (pc_in == bp_addr);
`endif

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
`ifdef BREAKPOINT_EN
      bp_hit_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
`ifdef BREAKPOINT_EN
      bp_hit_q <= bp_hit_d;
`endif
    end
  end

  // Normal sequencing first, then halt overrides the next state, then a soft
  // reset press overrides everything including any strobe in this cycle.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    ce       = 1'b0;
`ifdef BREAKPOINT_EN
    bp_hit_d = bp_hit_q;
    if (run_rise || step_press) begin
      bp_hit_d = 1'b0;
    end
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (run_rise) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else if (step_press) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (!run_sync2_q) begin
          state_d = ST_IDLE;
          div_d   = '0;
        end else if (div_last) begin
          div_d = '0;
`ifdef BREAKPOINT_EN
          if (bp_match) begin
            state_d  = ST_IDLE;
            bp_hit_d = 1'b1;
          end else begin
            ce = 1'b1;
          end
`else
          ce = 1'b1;
`endif
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_STEP: begin
        ce      = 1'b1;
        state_d = ST_IDLE;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ce) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (halt_in && (state_q != ST_HALTED)) begin
      state_d = ST_HALTED;
    end

    if (rst_press) begin
      state_d  = ST_IDLE;
      div_d    = '0;
      cnt_d    = '0;
      ce       = 1'b0;
`ifdef BREAKPOINT_EN
      bp_hit_d = 1'b0;
`endif
    end
  end

  assign cpu_ce    = ce;
  assign cpu_rst   = rst_press;
  assign state_o   = state_q;
  assign cycle_cnt = cnt_q;
`ifdef BREAKPOINT_EN
  assign bp_hit    = bp_hit_q;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with TICK_DIV=4, DEB_CYC=3, CNT_W=8;
// the breakpoint scenario is included when BREAKPOINT_EN is defined.
module tb_cpu_run_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DEB_CYC  = 3;
  localparam int CNT_W    = 8;

  logic             clk     = 1'b0;
  logic             RESETn  = 1'b1;
  logic             runSw   = 1'b0;
  logic             stepBtn = 1'b0;
  logic             rstBtn  = 1'b0;
  logic             haltIn  = 1'b0;
  logic             cpuCe, cpuRst;
  logic [1:0]       stateO;
  logic [CNT_W-1:0] cycleCnt;
`ifdef BREAKPOINT_EN
  logic [7:0]       pcIn   = 8'h00;
  logic [7:0]       bpAddr = 8'h05;
  logic             bpEn   = 1'b0;
  logic             bpHit;
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int ceSeen      = 0;
  int rstSeen     = 0;
  int overlapSeen = 0;
  int expCnt      = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .TICK_DIV (TICK_DIV),
    .DEB_CYC  (DEB_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .RESETn    (RESETn),
    .run_sw    (runSw),
    .step_btn  (stepBtn),
    .rst_btn   (rstBtn),
    .halt_in   (haltIn),
`ifdef BREAKPOINT_EN
    .pc_in     (pcIn),
    .bp_addr   (bpAddr),
    .bp_en     (bpEn),
    .bp_hit    (bpHit),
`endif
    .cpu_ce    (cpuCe),
    .cpu_rst   (cpuRst),
    .state_o   (stateO),
    .cycle_cnt (cycleCnt)
  );

  // Strobe tally, sampled mid-cycle.
  always @(negedge clk) begin
    if (RESETn) begin
      if (cpuCe === 1'b1) ceSeen++;
      if (cpuRst === 1'b1) rstSeen++;
      if (cpuCe === 1'b1 && cpuRst === 1'b1) overlapSeen++;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic waitState(input logic [1:0] want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (stateO === want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int base;
    #2 RESETn = 1'b0;
    #1;
    testsRun++; if (stateO !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_state: got %0d expected 0", stateO); end
    testsRun++; if (cpuCe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ce: got %0b expected 0", cpuCe); end
    testsRun++; if (cpuRst !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rst: got %0b expected 0", cpuRst); end
    testsRun++; if (cycleCnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cycleCnt); end
    repeat (3) cyc();
    RESETn = 1'b1;
    repeat (5) cyc();
    runSw = 1'b1;
    waitState(2'd1, 10, ok);
    testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_enter_run: got %0b expected 1", ok); end
    repeat (6) cyc();
    testsRun++; if (cycleCnt !== 8'd1) begin testsFailed++; $display("[TB] FAIL reset_pre_cnt: got %0d expected 1", cycleCnt); end
    RESETn = 1'b0;
    #1;
    testsRun++; if (stateO !== 2'd0) begin testsFailed++; $display("[TB] FAIL async_state: got %0d expected 0", stateO); end
    testsRun++; if (cpuCe !== 1'b0) begin testsFailed++; $display("[TB] FAIL async_ce: got %0b expected 0", cpuCe); end
    testsRun++; if (cycleCnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL async_cnt: got %0d expected 0", cycleCnt); end
    cyc();
    RESETn = 1'b1;
    base = ceSeen;
    repeat (20) cyc();
    testsRun++; if (stateO !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_stay_idle: got %0d expected 0", stateO); end
    testsRun++; if (ceSeen - base !== 0) begin testsFailed++; $display("[TB] FAIL reset_no_ce: got %0d expected 0", ceSeen - base); end
    runSw = 1'b0;
    repeat (5) cyc();
    expCnt = 0;
  endtask

  task automatic test_run();
    bit ok;
    int total, base;
    logic expCe;
    total = TICK_DIV * (10 + int'($urandom_range(0, 4)));
    runSw = 1'b1;
    waitState(2'd1, 10, ok);
    testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL run_enter: got %0b expected 1", ok); end
    base = ceSeen;
    for (int n = 0; n < total; n++) begin
      expCe = ((n + 1) % TICK_DIV) == 0;
      testsRun++; if (cpuCe !== expCe) begin testsFailed++; $display("[TB] FAIL run_ce n=%0d: got %0b expected %0b", n, cpuCe, expCe); end
      testsRun++; if (cycleCnt !== 8'(expCnt + n / TICK_DIV)) begin testsFailed++; $display("[TB] FAIL run_cnt n=%0d: got %0d expected %0d", n, cycleCnt, 8'(expCnt + n / TICK_DIV)); end
      if (n == 10 * TICK_DIV) begin
        testsRun++; if (cycleCnt !== 8'(expCnt + 10)) begin testsFailed++; $display("[TB] FAIL run_ten_strobes: got %0d expected %0d", cycleCnt, 8'(expCnt + 10)); end
      end
      stepBtn = (n >= 5 && n < 11);
      cyc();
    end
    testsRun++; if (ceSeen - base !== total / TICK_DIV) begin testsFailed++; $display("[TB] FAIL run_strobe_total: got %0d expected %0d", ceSeen - base, total / TICK_DIV); end
    expCnt += total / TICK_DIV;
    runSw = 1'b0;
    base = ceSeen;
    repeat (20) cyc();
    testsRun++; if (stateO !== 2'd0) begin testsFailed++; $display("[TB] FAIL run_stop_state: got %0d expected 0", stateO); end
    testsRun++; if (ceSeen - base !== 0) begin testsFailed++; $display("[TB] FAIL run_stop_no_ce: got %0d expected 0", ceSeen - base); end
    testsRun++; if (cycleCnt !== 8'(expCnt)) begin testsFailed++; $display("[TB] FAIL run_stop_cnt: got %0d expected %0d", cycleCnt, 8'(expCnt)); end
  endtask

  task automatic test_step();
    int presses, base, b;
    bit sawStep;
    presses = int'($urandom_range(2, 3));
    for (int p = 0; p < presses; p++) begin
      base = ceSeen;
      sawStep = 1'b0;
      for (int seg = 0; seg < 4; seg++) begin
        stepBtn = (seg % 2) == 0;
        b = int'($urandom_range(1, 2));
        repeat (b) cyc();
      end
      stepBtn = 1'b1;
      for (int i = 0; i < 20; i++) begin
        cyc();
        if (stateO === 2'd2) sawStep = 1'b1;
      end
      stepBtn = 1'b0;
      repeat (15) cyc();
      testsRun++; if (ceSeen - base !== 1) begin testsFailed++; $display("[TB] FAIL step_one_ce p=%0d: got %0d expected 1", p, ceSeen - base); end
      testsRun++; if (sawStep !== 1'b1) begin testsFailed++; $display("[TB] FAIL step_state_seen p=%0d: got %0b expected 1", p, sawStep); end
      expCnt++;
      testsRun++; if (cycleCnt !== 8'(expCnt)) begin testsFailed++; $display("[TB] FAIL step_cnt p=%0d: got %0d expected %0d", p, cycleCnt, 8'(expCnt)); end
      testsRun++; if (stateO !== 2'd0) begin testsFailed++; $display("[TB] FAIL step_back_idle p=%0d: got %0d expected 0", p, stateO); end
    end
  endtask

  task automatic test_halt();
    bit ok;
    int k, base;
    k = int'($urandom_range(1, 3));
    runSw = 1'b1;
    waitState(2'd1, 10, ok);
    testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL halt_enter_run: got %0b expected 1", ok); end
    repeat (TICK_DIV * k - 1) cyc();
    testsRun++; if (cpuCe !== 1'b1) begin testsFailed++; $display("[TB] FAIL halt_strobe_cycle: got %0b expected 1", cpuCe); end
    haltIn = 1'b1;
    cyc();
    haltIn = 1'b0;
    expCnt += k;
    testsRun++; if (stateO !== 2'd3) begin testsFailed++; $display("[TB] FAIL halt_state: got %0d expected 3", stateO); end
    testsRun++; if (cycleCnt !== 8'(expCnt)) begin testsFailed++; $display("[TB] FAIL halt_cnt: got %0d expected %0d", cycleCnt, 8'(expCnt)); end
    base = ceSeen;
    runSw = 1'b0; repeat (5) cyc();
    runSw = 1'b1; repeat (5) cyc();
    runSw = 1'b0;
    stepBtn = 1'b1; repeat (10) cyc();
    stepBtn = 1'b0; repeat (10) cyc();
    testsRun++; if (ceSeen - base !== 0) begin testsFailed++; $display("[TB] FAIL halt_no_ce: got %0d expected 0", ceSeen - base); end
    testsRun++; if (stateO !== 2'd3) begin testsFailed++; $display("[TB] FAIL halt_stays: got %0d expected 3", stateO); end
  endtask

  task automatic test_rst_halted();
    bit seen;
    int base;
    base = rstSeen;
    seen = 1'b0;
    haltIn = 1'b1;
    rstBtn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (cpuRst === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    testsRun++; if (seen !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_pulse_seen: got %0b expected 1", seen); end
    testsRun++; if (cpuCe !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_no_ce: got %0b expected 0", cpuCe); end
    cyc();
    haltIn = 1'b0;
    expCnt = 0;
    testsRun++; if (stateO !== 2'd0) begin testsFailed++; $display("[TB] FAIL rst_state: got %0d expected 0", stateO); end
    testsRun++; if (cycleCnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL rst_cnt: got %0d expected 0", cycleCnt); end
    testsRun++; if (cpuRst !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_single: got %0b expected 0", cpuRst); end
    repeat (15) cyc();
    rstBtn = 1'b0;
    repeat (10) cyc();
    testsRun++; if (rstSeen - base !== 1) begin testsFailed++; $display("[TB] FAIL rst_pulse_count: got %0d expected 1", rstSeen - base); end
    testsRun++; if (stateO !== 2'd0) begin testsFailed++; $display("[TB] FAIL rst_stay_idle: got %0d expected 0", stateO); end
  endtask

  task automatic test_wrap();
    bit ok, seen;
    int total;
    logic expCe;
    total = TICK_DIV * 258;
    runSw = 1'b1;
    waitState(2'd1, 10, ok);
    testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL wrap_enter_run: got %0b expected 1", ok); end
    for (int n = 0; n < total; n++) begin
      expCe = ((n + 1) % TICK_DIV) == 0;
      testsRun++; if (cpuCe !== expCe) begin testsFailed++; $display("[TB] FAIL wrap_ce n=%0d: got %0b expected %0b", n, cpuCe, expCe); end
      testsRun++; if (cycleCnt !== 8'(expCnt + n / TICK_DIV)) begin testsFailed++; $display("[TB] FAIL wrap_cnt n=%0d: got %0d expected %0d", n, cycleCnt, 8'(expCnt + n / TICK_DIV)); end
      if (n == 255 * TICK_DIV) begin
        testsRun++; if (cycleCnt !== 8'd255) begin testsFailed++; $display("[TB] FAIL wrap_at_255: got %0d expected 255", cycleCnt); end
      end
      if (n == 256 * TICK_DIV) begin
        testsRun++; if (cycleCnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL wrap_to_0: got %0d expected 0", cycleCnt); end
      end
      cyc();
    end
    seen = 1'b0;
    rstBtn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (cpuRst === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    testsRun++; if (seen !== 1'b1) begin testsFailed++; $display("[TB] FAIL run_rst_seen: got %0b expected 1", seen); end
    testsRun++; if (cpuCe !== 1'b0) begin testsFailed++; $display("[TB] FAIL run_rst_no_ce: got %0b expected 0", cpuCe); end
    cyc();
    expCnt = 0;
    testsRun++; if (stateO !== 2'd0) begin testsFailed++; $display("[TB] FAIL run_rst_state: got %0d expected 0", stateO); end
    testsRun++; if (cycleCnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL run_rst_cnt: got %0d expected 0", cycleCnt); end
    rstBtn = 1'b0;
    repeat (12) cyc();
    testsRun++; if (stateO !== 2'd0) begin testsFailed++; $display("[TB] FAIL run_rst_stay_idle: got %0d expected 0", stateO); end
    runSw = 1'b0;
    repeat (5) cyc();
  endtask

`ifdef BREAKPOINT_EN
  task automatic test_breakpoint();
    bit ok;
    int base;
    bpEn = 1'b1;
    pcIn = 8'h03;
    runSw = 1'b1;
    waitState(2'd1, 10, ok);
    testsRun++; if (ok !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_enter_run: got %0b expected 1", ok); end
    repeat (TICK_DIV - 1) cyc();
    testsRun++; if (cpuCe !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_first_strobe: got %0b expected 1", cpuCe); end
    pcIn = 8'h05;
    repeat (TICK_DIV) cyc();
    testsRun++; if (cpuCe !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_suppress: got %0b expected 0", cpuCe); end
    cyc();
    expCnt++;
    testsRun++; if (stateO !== 2'd0) begin testsFailed++; $display("[TB] FAIL bp_idle: got %0d expected 0", stateO); end
    testsRun++; if (bpHit !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_hit_set: got %0b expected 1", bpHit); end
    testsRun++; if (cycleCnt !== 8'(expCnt)) begin testsFailed++; $display("[TB] FAIL bp_cnt: got %0d expected %0d", cycleCnt, 8'(expCnt)); end
    base = ceSeen;
    stepBtn = 1'b1; repeat (12) cyc();
    stepBtn = 1'b0; repeat (8) cyc();
    expCnt++;
    testsRun++; if (ceSeen - base !== 1) begin testsFailed++; $display("[TB] FAIL bp_step_ce: got %0d expected 1", ceSeen - base); end
    testsRun++; if (bpHit !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_hit_clear: got %0b expected 0", bpHit); end
    testsRun++; if (cycleCnt !== 8'(expCnt)) begin testsFailed++; $display("[TB] FAIL bp_step_cnt: got %0d expected %0d", cycleCnt, 8'(expCnt)); end
    runSw = 1'b0;
    bpEn = 1'b0;
    repeat (5) cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_run();
    test_step();
    test_halt();
    test_rst_halted();
    test_wrap();
`ifdef BREAKPOINT_EN
    test_breakpoint();
`endif
    testsRun++;
    if (overlapSeen !== 0) begin
      testsFailed++;
      $display("[TB] FAIL ce_rst_overlap: got %0d expected 0", overlapSeen);
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
